mac_accum_drain: RTL and testbench

- Consumer end of the parallel multiplier array.
- Takes the N-lane product buses (two per lane: weight1×data and weight2×data) and reduces each bus across lanes with a pipelined adder tree.
- Accumulates the two lane-sums over a multi-beat dot product delimited by in_last, then drains the two results through a valid/ready output with a 2-entry result buffer.
- Sits between the multiplier array and the layer output writer.

---
 rtl/mac_pkg.sv | 21 ++
 rtl/mac_reduce_tree.sv | 59 +++++
 rtl/mac_accum_drain.sv | 133 +++++++++++++
 tb/tb_mac_accum_drain.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared constants, helpers and result record for the MAC drain datapath.
package mac_pkg;
  localparam int PROD_W     = 16;
  localparam int ACC_W_DEF  = 32;
  localparam int BEAT_W_DEF = 16;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Result record at the default widths; the top re-declares it at its own ACC_W/BEAT_W.
  typedef struct packed {
    logic signed [ACC_W_DEF-1:0] acc1;
    logic signed [ACC_W_DEF-1:0] acc2;
    logic [BEAT_W_DEF-1:0]       beats;
    logic [1:0]                  ovf;
  } mac_result_t;
endpackage

// File: rtl/mac_reduce_tree.sv
// Two-stage signed lane reducer: registered group sums, then registered lane total.
module mac_reduce_tree
  import mac_pkg::*;
#(
  parameter  int N      = 144,
  parameter  int GROUP  = 12,
  localparam int NG     = (N + GROUP - 1) / GROUP,
  localparam int GRP_W  = PROD_W + clog2(GROUP),
  localparam int TOT_W  = PROD_W + clog2(N),
  localparam int STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [PROD_W*N-1:0]     prod,
  output logic                    out_valid,
  output logic signed [TOT_W-1:0] sum
);
  logic [PROD_W*NG*GROUP-1:0] pad;
  logic [GRP_W*NG-1:0]        grp_d, grp_q;
  logic signed [TOT_W-1:0]    tot_d;
  logic [STAGES:1]            vld_pipe;

  // Lanes past N read as zero so the last group can be short.
  always_comb begin
    pad = '0;
    pad[PROD_W*N-1:0] = prod;
  end

  for (genvar g = 0; g < NG; g++) begin : g_grp
    logic signed [GRP_W-1:0] s;
    always_comb begin
      s = '0;
      for (int k = 0; k < GROUP; k++)
        s = s + GRP_W'($signed(pad[(g*GROUP+k)*PROD_W +: PROD_W]));
    end
    assign grp_d[g*GRP_W +: GRP_W] = s;
  end

  always_comb begin
    tot_d = '0;
    for (int g = 0; g < NG; g++)
      tot_d = tot_d + TOT_W'($signed(grp_q[g*GRP_W +: GRP_W]));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grp_q    <= '0;
      sum      <= '0;
      vld_pipe <= '0;
    end else begin
      grp_q    <= grp_d;
      sum      <= tot_d;
      vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
    end
  end

  assign out_valid = vld_pipe[STAGES];
endmodule

// File: rtl/mac_accum_drain.sv
// Lane-reduce two product buses, accumulate per dot product, drain via a 2-entry result FIFO.
module mac_accum_drain
  import mac_pkg::*;
#(
  parameter int N      = 144,
  parameter int GROUP  = 12,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int BEAT_W = BEAT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PROD_W*N-1:0]     mul_out1,
  input  logic [PROD_W*N-1:0]     mul_out2,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic signed [ACC_W-1:0] acc_out1,
  output logic signed [ACC_W-1:0] acc_out2,
  output logic [BEAT_W-1:0]       acc_beats,
  output logic [1:0]              acc_ovf,
  output logic                    out_valid,
  input  logic                    out_ready
);
  localparam int TOT_W = PROD_W + clog2(N);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef struct packed {
    logic signed [ACC_W-1:0] acc1;
    logic signed [ACC_W-1:0] acc2;
    logic [BEAT_W-1:0]       beats;
    logic [1:0]              ovf;
  } res_t;

  // Returns {saturated, value}.
  function automatic logic [ACC_W:0] sat_add(input logic signed [ACC_W-1:0] a,
                                             input logic signed [TOT_W-1:0] b);
    logic signed [ACC_W:0] s;
    s = (ACC_W+1)'(a) + (ACC_W+1)'(b);
    if (s[ACC_W] != s[ACC_W-1]) begin
      if (s[ACC_W]) return {1'b1, ACC_MIN};
      return {1'b1, ACC_MAX};
    end
    return {1'b0, s[ACC_W-1:0]};
  endfunction

  logic                    accept, tv1, tv2, acc_vld, push, pop;
  logic signed [TOT_W-1:0] tot1, tot2;
  logic [2:1]              last_pipe;
  logic signed [ACC_W-1:0] acc1_q, acc2_q;
  logic [BEAT_W-1:0]       beats_q;
  logic [1:0]              ovf_q;
  logic [ACC_W:0]          r1, r2;
  res_t                    res_nxt;
  res_t                    mem [2];
  logic                    wr_ptr, rd_ptr;
  logic [1:0]              count;
  logic [2:0]              credits;

  assign accept = in_valid && in_ready;

  mac_reduce_tree #(.N(N), .GROUP(GROUP)) u_tree1 (
    .clk(clk), .rst(rst), .in_valid(accept), .prod(mul_out1), .out_valid(tv1), .sum(tot1)
  );
  mac_reduce_tree #(.N(N), .GROUP(GROUP)) u_tree2 (
    .clk(clk), .rst(rst), .in_valid(accept), .prod(mul_out2), .out_valid(tv2), .sum(tot2)
  );

  // Both trees see the same valid; AND keeps them symmetric.
  assign acc_vld = tv1 && tv2;
  assign push    = acc_vld && last_pipe[2];
  assign pop     = out_valid && out_ready;

  always_comb begin
    r1            = sat_add(acc1_q, tot1);
    r2            = sat_add(acc2_q, tot2);
    res_nxt       = '0;
    res_nxt.acc1  = r1[ACC_W-1:0];
    res_nxt.acc2  = r2[ACC_W-1:0];
    res_nxt.beats = (beats_q == '1) ? beats_q : beats_q + BEAT_W'(1);
    res_nxt.ovf   = ovf_q | {r2[ACC_W], r1[ACC_W]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_pipe <= '0;
      acc1_q    <= '0;
      acc2_q    <= '0;
      beats_q   <= '0;
      ovf_q     <= '0;
    end else begin
      last_pipe <= {last_pipe[1], accept && in_last};
      if (acc_vld) begin
        if (last_pipe[2]) begin
          acc1_q  <= '0;
          acc2_q  <= '0;
          beats_q <= '0;
          ovf_q   <= '0;
        end else begin
          acc1_q  <= res_nxt.acc1;
          acc2_q  <= res_nxt.acc2;
          beats_q <= res_nxt.beats;
          ovf_q   <= res_nxt.ovf;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= res_nxt;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

  // Every last-flagged beat in flight reserves a buffer slot, so the FIFO cannot overflow.
  assign credits   = 3'(count) + 3'(last_pipe[1]) + 3'(last_pipe[2]);
  assign in_ready  = !rst && (credits < 3'd2);
  assign out_valid = (count != 2'd0);
  assign acc_out1  = mem[rd_ptr].acc1;
  assign acc_out2  = mem[rd_ptr].acc2;
  assign acc_beats = mem[rd_ptr].beats;
  assign acc_ovf   = mem[rd_ptr].ovf;
endmodule

// File: tb/tb_mac_accum_drain.sv
// Bench: table vectors, directed corner sequences and random traffic against a queue model.
module tb_mac_accum_drain;
  localparam int NB = 144;
  localparam int NS = 4;
  localparam longint AMAX = 2147483647;
  localparam longint AMIN = -AMAX - 1;
  localparam longint BMAX = 65535;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [16*NB-1:0]   mul1, mul2;
  logic               in_valid, in_last, in_ready, out_valid, out_ready;
  logic signed [31:0] acc1, acc2;
  logic [15:0]        beats;
  logic [1:0]         ovf;

  logic [16*NS-1:0]   s_mul1, s_mul2;
  logic               s_in_valid, s_in_last, s_in_ready, s_out_valid, s_out_ready;
  logic signed [19:0] s_acc1, s_acc2;
  logic [2:0]         s_beats;
  logic [1:0]         s_ovf;

  int checks = 0, failures = 0;

  mac_accum_drain #(.N(NB), .GROUP(12), .ACC_W(32), .BEAT_W(16)) dut (
    .clk(clk), .rst(rst), .mul_out1(mul1), .mul_out2(mul2), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .acc_out1(acc1), .acc_out2(acc2),
    .acc_beats(beats), .acc_ovf(ovf), .out_valid(out_valid), .out_ready(out_ready)
  );

  mac_accum_drain #(.N(NS), .GROUP(3), .ACC_W(20), .BEAT_W(3)) dut_s (
    .clk(clk), .rst(rst), .mul_out1(s_mul1), .mul_out2(s_mul2), .in_valid(s_in_valid),
    .in_last(s_in_last), .in_ready(s_in_ready), .acc_out1(s_acc1), .acc_out2(s_acc2),
    .acc_beats(s_beats), .acc_ovf(s_ovf), .out_valid(s_out_valid), .out_ready(s_out_ready)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: dot products as plain integer sums with clamping.
  typedef struct {longint a1; longint a2; longint b; int o;} mres_t;
  mres_t  exp_q[$];
  longint m1 = 0, m2 = 0, mb = 0;
  int     mo = 0;

  always @(negedge clk) begin
    longint s1, s2;
    mres_t  r;
    if (rst) begin
      m1 = 0; m2 = 0; mb = 0; mo = 0;
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("mon_unexpected_result", 1, 0);
        else begin
          r = exp_q.pop_front();
          chk("mon_acc1", acc1, r.a1);
          chk("mon_acc2", acc2, r.a2);
          chk("mon_beats", beats, r.b);
          chk("mon_ovf", ovf, r.o);
        end
      end
      if (in_valid && in_ready) begin
        s1 = 0; s2 = 0;
        for (int i = 0; i < NB; i++) begin
          s1 += longint'($signed(mul1[16*i +: 16]));
          s2 += longint'($signed(mul2[16*i +: 16]));
        end
        m1 += s1; m2 += s2;
        if (m1 > AMAX) begin m1 = AMAX; mo |= 1; end
        if (m1 < AMIN) begin m1 = AMIN; mo |= 1; end
        if (m2 > AMAX) begin m2 = AMAX; mo |= 2; end
        if (m2 < AMIN) begin m2 = AMIN; mo |= 2; end
        if (mb < BMAX) mb++;
        if (in_last) begin
          r.a1 = m1; r.a2 = m2; r.b = mb; r.o = mo;
          exp_q.push_back(r);
          m1 = 0; m2 = 0; mb = 0; mo = 0;
        end
      end
    end
  end

  function automatic logic [16*NB-1:0] fill(input int v);
    logic [16*NB-1:0] r;
    for (int i = 0; i < NB; i++) r[16*i +: 16] = 16'(v);
    return r;
  endfunction

  function automatic logic [16*NS-1:0] sfill(input int v, input int step);
    logic [16*NS-1:0] r;
    for (int i = 0; i < NS; i++) r[16*i +: 16] = 16'(v + step*i);
    return r;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [16*NB-1:0] p1, input logic [16*NB-1:0] p2,
                      input logic last, output int n);
    mul1 = p1; mul2 = p2; in_last = last; in_valid = 1'b1; n = 0;
    do begin @(negedge clk); n++; end while (!in_ready && n < 100);
    if (!in_ready) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic s_send(input logic [16*NS-1:0] p1, input logic [16*NS-1:0] p2,
                        input logic last);
    int n;
    s_mul1 = p1; s_mul2 = p2; s_in_last = last; s_in_valid = 1'b1; n = 0;
    do begin @(negedge clk); n++; end while (!s_in_ready && n < 100);
    if (!s_in_ready) chk("s_send_timeout", 0, 1);
    @(posedge clk); #1;
    s_in_valid = 1'b0; s_in_last = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 50);
  endtask

  task automatic s_wait_out(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!s_out_valid && n < 50);
  endtask

  typedef struct {int v1; int v2; int nb; longint e1; longint e2; longint eb; int eo;} vec_t;
  vec_t tbl[5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k;
    longint g1[2], gb[2];
    tbl[0] = '{1, -2, 3, 432, -864, 3, 0};
    tbl[1] = '{32767, -32768, 1, 4718448, -4718592, 1, 0};
    tbl[2] = '{-1, 5, 2, -288, 1440, 2, 0};
    tbl[3] = '{32767, -32768, 460, AMAX, AMIN, 460, 3};
    tbl[4] = '{0, 0, 1, 0, 0, 1, 0};

    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; mul1 = '0; mul2 = '0; out_ready = 1'b1;
    s_in_valid = 1'b0; s_in_last = 1'b0; s_mul1 = '0; s_mul2 = '0; s_out_ready = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_acc1", acc1, 0);
    chk("rst_acc2", acc2, 0);
    chk("rst_beats", beats, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_s_out_valid", s_out_valid, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", in_ready, 1);

    // Uniform-lane dot products, latency measured from the last accept.
    for (int i = 0; i < 5; i++) begin
      for (int b = 0; b < tbl[i].nb; b++)
        send(fill(tbl[i].v1), fill(tbl[i].v2), b == tbl[i].nb - 1, n);
      wait_out(n);
      chk("tbl_latency", n, 3);
      chk("tbl_acc1", acc1, tbl[i].e1);
      chk("tbl_acc2", acc2, tbl[i].e2);
      chk("tbl_beats", beats, tbl[i].eb);
      chk("tbl_ovf", ovf, tbl[i].eo);
      @(posedge clk); #1;
    end

    // Back-to-back dot products with no gap.
    repeat (4) @(posedge clk); #1;
    send(fill(1), fill(1), 1'b0, n); chk("b2b_gap0", n, 1);
    send(fill(2), fill(2), 1'b1, n); chk("b2b_gap1", n, 1);
    send(fill(3), fill(3), 1'b1, n); chk("b2b_gap2", n, 1);
    k = 0;
    for (int c = 0; c < 20 && k < 2; c++) begin
      @(negedge clk);
      if (out_valid) begin g1[k] = acc1; gb[k] = beats; k++; end
    end
    chk("b2b_count", k, 2);
    chk("b2b_acc1_0", g1[0], 432);
    chk("b2b_beats_0", gb[0], 2);
    chk("b2b_acc1_1", g1[1], 432);
    chk("b2b_beats_1", gb[1], 1);

    // Backpressure: two results fill the credits, third beat waits.
    repeat (4) @(posedge clk); #1;
    out_ready = 1'b0;
    send(fill(1), fill(1), 1'b1, n);
    send(fill(2), fill(2), 1'b1, n);
    mul1 = fill(3); mul2 = fill(3); in_valid = 1'b1; in_last = 1'b1;
    repeat (4) begin @(negedge clk); chk("bp_hold_ready", in_ready, 0); end
    chk("bp_out_valid", out_valid, 1);
    chk("bp_head0", acc1, 144);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_pop_cycle", in_ready, 0);
    chk("bp_pop_head", acc1, 144);
    @(negedge clk);
    chk("bp_ready_after_pop", in_ready, 1);
    chk("bp_head1", acc1, 288);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    repeat (6) @(posedge clk); #1;

    // in_last without in_valid must not close the dot product.
    send(fill(1), fill(1), 1'b0, n);
    in_last = 1'b1;
    repeat (5) begin @(negedge clk); chk("ign_last_no_out", out_valid, 0); end
    @(posedge clk); #1;
    send(fill(2), fill(2), 1'b1, n);
    wait_out(n);
    chk("ign_last_acc1", acc1, 432);
    chk("ign_last_beats", beats, 2);

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom % 4) != 0;
      in_last   = ($urandom % 4) == 0;
      out_ready = ($urandom % 3) != 0;
      for (int i = 0; i < NB; i++) begin
        mul1[16*i +: 16] = 16'($urandom);
        mul2[16*i +: 16] = 16'($urandom);
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    repeat (20) @(posedge clk); #1;
    chk("rand_drained", exp_q.size(), 0);

    // Async reset mid dot product with a result pending.
    out_ready = 1'b0;
    send(fill(5), fill(5), 1'b1, n);
    wait_out(n);
    @(posedge clk); #1;
    send(fill(1), fill(1), 1'b0, n);
    mul1 = fill(1); mul2 = fill(1); in_valid = 1'b1; in_last = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_acc1", acc1, 0);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(fill(1), fill(1), 1'b1, n);
    wait_out(n);
    chk("post_rst_acc1", acc1, 144);
    chk("post_rst_beats", beats, 1);
    @(posedge clk); #1;

    // Small instance: 20-bit saturation, short last group, beat counter clamp.
    for (int b = 0; b < 5; b++) s_send(sfill(32767, 0), sfill(-32768, 0), b == 4);
    s_wait_out(n);
    chk("sat_latency", n, 3);
    chk("sat_acc1", s_acc1, 524287);
    chk("sat_acc2", s_acc2, -524288);
    chk("sat_ovf", s_ovf, 3);
    chk("sat_beats", s_beats, 5);
    @(posedge clk); #1;
    s_send(sfill(1, 0), sfill(1, 0), 1'b1);
    s_wait_out(n);
    chk("sat_next_acc1", s_acc1, 4);
    chk("sat_next_ovf", s_ovf, 0);
    chk("sat_next_beats", s_beats, 1);
    @(posedge clk); #1;
    for (int b = 0; b < 9; b++) s_send(sfill(1, 1), sfill(-1, -1), b == 8);
    s_wait_out(n);
    chk("pad_acc1", s_acc1, 90);
    chk("pad_acc2", s_acc2, -90);
    chk("beat_clamp", s_beats, 7);
    chk("pad_ovf", s_ovf, 0);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
